// File: rtl/cardinal_pkg.sv
// Shared Cardinal execute-stage definitions: lane width codes,
// participation codes, divider FSM states and lane-mask helpers.
package cardinal_pkg;

    // Lane width select carried in the ww field
    typedef enum logic [1:0] {
        WW_B = 2'b00,
        WW_H = 2'b01,
        WW_W = 2'b10,
        WW_D = 2'b11
    } ww_e;

    // Participation field, shared with the register file write port
    typedef enum logic [2:0] {
        PPP_A = 3'b000,
        PPP_U = 3'b001,
        PPP_D = 3'b010,
        PPP_E = 3'b011,
        PPP_O = 3'b100
    } ppp_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } vdiv_state_e;

    function automatic logic [6:0] lane_width(input logic [1:0] ww);
        logic [6:0] w;
        case (ww)
            WW_B:    w = 7'd8;
            WW_H:    w = 7'd16;
            WW_W:    w = 7'd32;
            default: w = 7'd64;
        endcase
        return w;
    endfunction

    // One bit set at the least significant position of every lane
    function automatic logic [63:0] lane_lsb_mask(input logic [1:0] ww);
        logic [63:0] m;
        case (ww)
            WW_B:    m = 64'h0101_0101_0101_0101;
            WW_H:    m = 64'h0001_0001_0001_0001;
            WW_W:    m = 64'h0000_0001_0000_0001;
            default: m = 64'h0000_0000_0000_0001;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/vdiv_step.sv
// One restoring-division step applied to every lane of a 64-bit word.
// Ports: rem_i/dvd_i/dsr_i current state, lsb_i lane mask; rem_o/dvd_o next state.
module vdiv_step (
    input  logic [63:0] rem_i,
    input  logic [63:0] dvd_i,
    input  logic [63:0] dsr_i,
    input  logic [63:0] lsb_i,
    output logic [63:0] rem_o,
    output logic [63:0] dvd_o
);

    logic [63:0] msb;
    logic [63:0] dtop;
    logic [63:0] rem_sh;
    logic [63:0] dvd_sh;
    logic [63:0] diff;
    logic [63:0] ge;
    logic [63:0] sel;
    logic        t;
    logic        b;
    logic        bi;
    logic        g;

    always_comb begin
        // A lane's MSB sits just below the next lane's LSB
        msb = {1'b1, lsb_i[63:1]};

        // Spread each lane's dividend MSB down so it can enter at the lane LSB
        dtop = '0;
        t    = 1'b0;
        for (int j = 63; j >= 0; j--) begin
            if (msb[j]) t = dvd_i[j];
            dtop[j] = t;
        end

        rem_sh = ({rem_i[62:0], 1'b0} & ~lsb_i) | (dtop & lsb_i);
        dvd_sh = {dvd_i[62:0], 1'b0} & ~lsb_i;

        // Ripple subtract; borrow restarts at every lane LSB
        diff = '0;
        ge   = '0;
        b    = 1'b0;
        bi   = 1'b0;
        for (int j = 0; j < 64; j++) begin
            bi      = lsb_i[j] ? 1'b0 : b;
            diff[j] = rem_sh[j] ^ dsr_i[j] ^ bi;
            b       = (~rem_sh[j] & dsr_i[j]) |
                      (~(rem_sh[j] ^ dsr_i[j]) & bi);
            // Bit shifted out of the remainder means it certainly fits
            if (msb[j]) ge[j] = rem_i[j] | ~b;
        end

        // Broadcast each lane's compare result over the whole lane
        sel = '0;
        g   = 1'b0;
        for (int j = 63; j >= 0; j--) begin
            if (msb[j]) g = ge[j];
            sel[j] = g;
        end

        rem_o = (sel & diff) | (~sel & rem_sh);
        dvd_o = dvd_sh | (sel & lsb_i);
    end

endmodule

// File: rtl/vdiv_unit.sv
// Multi-cycle partitioned unsigned divide/modulo unit (restoring, all lanes in parallel).
// Ports: clk/reset, start+ww+rem_sel+opA+opB+rd_in+ppp_in request; busy/done/result/rd_out/ppp_out.
module vdiv_unit
    import cardinal_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            ww,
    input  logic                  rem_sel,
    input  logic [DATA_WIDTH-1:0] opA,
    input  logic [DATA_WIDTH-1:0] opB,
    input  logic [ADDR_WIDTH-1:0] rd_in,
    input  logic [2:0]            ppp_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [ADDR_WIDTH-1:0] rd_out,
    output logic [2:0]            ppp_out
);

    vdiv_state_e           state_q;
    logic [5:0]            cnt_q;
    logic [63:0]           rem_q;
    logic [63:0]           dvd_q;
    logic [63:0]           dsr_q;
    logic [63:0]           lsb_q;
    logic                  sel_q;
    logic [ADDR_WIDTH-1:0] rdc_q;
    logic [2:0]            pppc_q;
    logic [63:0]           res_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic [2:0]            ppp_q;
    logic                  busy_q;
    logic                  done_q;
    logic [63:0]           rem_d;
    logic [63:0]           dvd_d;

    vdiv_step u_step (
        .rem_i (rem_q),
        .dvd_i (dvd_q),
        .dsr_i (dsr_q),
        .lsb_i (lsb_q),
        .rem_o (rem_d),
        .dvd_o (dvd_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            lsb_q   <= '0;
            sel_q   <= 1'b0;
            rdc_q   <= '0;
            pppc_q  <= '0;
            res_q   <= '0;
            rd_q    <= '0;
            ppp_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        dvd_q   <= opA;
                        dsr_q   <= opB;
                        lsb_q   <= lane_lsb_mask(ww);
                        rem_q   <= '0;
                        cnt_q   <= 6'(lane_width(ww) - 7'd1);
                        sel_q   <= rem_sel;
                        rdc_q   <= rd_in;
                        pppc_q  <= ppp_in;
                        busy_q  <= 1'b1;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    if (cnt_q == 6'd0) begin
                        // Result registers load as DONE is entered
                        res_q   <= sel_q ? rem_d : dvd_d;
                        rd_q    <= rdc_q;
                        ppp_q   <= pppc_q;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 6'd1;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = res_q;
    assign rd_out  = rd_q;
    assign ppp_out = ppp_q;

endmodule

// File: doc/vdiv_unit.md
# vdiv_unit

Multi-cycle partitioned unsigned divide/modulo unit for the Cardinal processor execute stage. It sits directly downstream of the 32x64 register file. It takes the two register read outputs (rA on read port 0, rB on read port 1) as dividend and divisor, divides every lane selected by the width field in parallel by restoring division, and returns the quotient or remainder. The destination address and ppp field are returned with the result, so writeback can drive the register file write port unchanged.

## Interface
Parameters:
- DATA_WIDTH, 64, operand/result width; only 64 is supported.
- ADDR_WIDTH, 5, destination register address width.

Ports:
- clk  in  1  clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in IDLE.
- ww  in  2  lane width: 00=8b, 01=16b, 10=32b, 11=64b.
- rem_sel  in  1  0=quotient (VDIV), 1=remainder (VMOD).
- opA  in  64  dividend, bits [0:63], bit 0 = MSB.
- opB  in  64  divisor, same layout.
- rd_in  in  5  destination register, captured on accept.
- ppp_in  in  3  participation field, captured on accept.
- busy  out  1  high in CALC and DONE.
- done  out  1  one-cycle pulse; result valid.
- result  out  64  quotient or remainder, all lanes.
- rd_out  out  5  captured rd_in.
- ppp_out  out  3  captured ppp_in.

## Operation
- Lane i of width W occupies bits [i*W : i*W+W-1]. Lanes never exchange bits; each lane is an independent unsigned divide.
- The FSM has three states: IDLE, CALC and DONE.
  - IDLE: start=1 captures opA, opB, ww, rem_sel, rd_in and ppp_in. Remainder registers are cleared, cnt is set to W-1, and the FSM goes to CALC.
  - CALC: one restoring step per cycle in every lane. The step computes {rem,dividend} <<= 1; if rem >= divisor, rem -= divisor and the quotient bit is set to 1. When cnt==0 the FSM goes to DONE; otherwise cnt decrements.
  - DONE: result is loaded from the quotient or the remainder according to the captured rem_sel. done=1 for this cycle only. The FSM then returns to IDLE.
- start in CALC or DONE is ignored and has no side effects.
- Divisor lane = 0 gives quotient lane all ones and remainder lane = dividend. This falls out of the algorithm; there is no special case and no error flag.
- The unit computes all lanes regardless of ppp. ppp is carried through only for the register file write.
- result, rd_out and ppp_out hold their values until the next DONE.
- Reset (any state, including mid-CALC) forces IDLE, busy=0, done=0, result=0, rd_out=0, ppp_out=0. The aborted operation is discarded.

## Timing
- Accept edge is cycle 0. CALC occupies cycles 1..W. done is high in cycle W+1, so latency = W+1 cycles: 9, 17, 33 or 65.
- The earliest next accept is cycle W+2, when start is seen in IDLE. Throughput is one operation per W+2 cycles.
- busy rises the cycle after accept and falls the cycle after done.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Structure
- Shared package `cardinal_pkg` holds:
  - ww encodings (WW_B, WW_H, WW_W, WW_D) and a function giving lane width from ww;
  - ppp encodings (A, U, D, E, O), shared with the register file;
  - FSM state typedef.
- Sub-module `vdiv_step` is combinational and implements one restoring step across 64 bits.
  - Inputs: rem, dividend, divisor, lane mask derived from ww.
  - The lane mask blocks shift and borrow propagation at lane boundaries.

## Test plan
- ww=00, opA byte0=200, opB byte0=7, rem_sel=0 → done at cycle 9, result byte0=28; rem_sel=1 → byte0=4.
- ww=01, opA=0xFFFF_0064_1234_0000, opB=0x0010_000A_0001_0003, rem_sel=0 → result=0x0FFF_000A_1234_0000 at cycle 17.
- ww=11, opA=100, opB=0, rem_sel=0 → result=0xFFFF_FFFF_FFFF_FFFF; rem_sel=1 → result=100; done at cycle 65.
- ww=10, start pulsed again in cycles 5 and 33 → ignored. One done at cycle 33; rd_out and ppp_out equal the first request's values.
- reset asserted in cycle 20 of a ww=11 operation → next cycle busy=0, done=0, result=0. A new start is then accepted and completes normally.
- Back-to-back ww=00 operations with start held high → done in cycles 9 and 19. result is stable between the two.
